decomp_fetch_queue: RTL
=======================

Name: decomp_fetch_queue

Overview:
Downstream stage of the decompressor. It buffers decompressed instructions with their PCs in a small FIFO and presents them to the CPU over a valid/ready handshake.
A single-word push carries a normal instruction. A two-word push carries a token expansion: both table words in one cycle.
A CPU redirect (branch/jump) flushes all queued entries so that stale fall-through instructions are never issued.

Parameters:
WIDTH, 32, word length of instructions and PCs
DEPTH, 8, queue entries; power of two, minimum 4
PCADD, 32'h4, PC increment applied to the second word of a two-word push

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer offers data this cycle
in_two  input  1  push carries two words (token expansion)
in_instr0  input  WIDTH  first (or only) instruction
in_instr1  input  WIDTH  second instruction; ignored when in_two=0
in_pc  input  WIDTH  PC of in_instr0
in_ready  output  1  queue can accept a push this cycle
out_valid  output  1  head entry is available
out_instr  output  WIDTH  head instruction
out_pc  output  WIDTH  head PC
out_ready  input  1  CPU consumes the head this cycle
flush  input  1  redirect: discard all entries
count  output  $clog2(DEPTH)+1  current occupancy
stat_flushes  output  16  flush counter (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, stat_flushes=0. Outputs: out_valid=0, out_instr=0, out_pc=0, in_ready=1. Storage contents are don't-care.
- in_ready = (count <= DEPTH-2). It is independent of in_two and of out_ready, so there is no combinational path from out_ready to in_ready.
- Push fires when in_valid & in_ready & !flush.
  - Single-word push: write {in_pc, in_instr0} at wr_ptr; wr_ptr += 1.
  - Two-word push: also write {in_pc+PCADD, in_instr1} at wr_ptr+1; wr_ptr += 2.
  - PC addition is modulo 2^WIDTH.
- Pop fires when out_valid & out_ready & !flush; rd_ptr += 1.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. A two-word push may straddle the wrap (slots DEPTH-1 and 0).
- count_next = count + pushed_words - popped. Simultaneous push and pop are both legal, including at count=DEPTH-2 (end result: count=DEPTH-1).
- out_valid = (count != 0).
- out_instr and out_pc show the head entry when out_valid=1, and are forced to 0 when the queue is empty.
- No bypass: a push into an empty queue becomes visible one cycle later. Push-to-out_valid latency is 1 cycle.
- Flush (synchronous): next cycle wr_ptr=rd_ptr=0 and count=0.
  - Flush has priority: any push or pop in the same cycle is discarded.
  - The producer must re-present the redirected stream from the cycle after the flush.
- Protocol:
  - in_valid with in_ready=0 has no effect. The producer holds its data until accepted.
  - Data must be stable while in_valid=1 and in_ready=0.
- Overflow is impossible by construction. Underflow is prevented by gating the pop with out_valid.
- Reset asserted mid-operation clears the queue immediately, regardless of clk.

Optional Feature:
- Macro DECOMP_QUEUE_STATS_EN.
- When defined: stat_flushes increments by 1 on every cycle with flush=1 and saturates at 16'hFFFF. It is cleared only by reset.
- When undefined: stat_flushes is tied to 16'h0 and no counter flops are generated. Port list is identical in both builds.

Decomposition:
- Shared package decomp_pkg holds:
  - typedef struct packed {logic [WIDTH-1:0] pc; logic [WIDTH-1:0] instr;} fq_entry_t
  - localparam DECOMP_PCADD
  - localparam FQ_PTR_W = $clog2(DEPTH)
- One natural sub-module: fq_storage. It is a DEPTH-entry register array with two write ports (addresses wp and wp+1, separate enables) and one asynchronous read port. Pointer, count and flush logic stay in the top module.

Test Plan:
- Reset, then one single push (pc=0x100, instr=0x00A00093) -> out_valid=1 on the next cycle with out_pc=0x100, out_instr=0x00A00093; pop with out_ready=1 -> count=0, out_instr=0.
- Two-word push (pc=0x200, instr0=0x11111111, instr1=0x22222222) -> count=2; pops return pc 0x200 then 0x204 in order.
- Fill with out_ready=0 and DEPTH=8 -> in_ready drops when count=7; a push offered at count=7 is not accepted and count stays 7.
- Wrap: advance pointers to wr_ptr=7, then push two words -> entries land in slots 7 and 0 and pop in order with correct PCs.
- Flush at count=5 with a simultaneous push and pop -> next cycle count=0, out_valid=0, push discarded; stat_flushes=1 with DECOMP_QUEUE_STATS_EN defined, 0 without.
- Assert reset asynchronously mid-burst (count=4, between clock edges) -> count=0 and out_valid=0 immediately; first post-reset push behaves as in scenario 1.

Source files
------------

// File: rtl/decomp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decomp_pkg
// Purpose  : Shared types and constants for the decompressor fetch queue.
// Revision : 1.0
// ============================================================================
package decomp_pkg;

   localparam int                      DECOMP_WIDTH = 32;
   localparam int                      DECOMP_DEPTH = 8;
   localparam logic [DECOMP_WIDTH-1:0] DECOMP_PCADD = 32'h4;
   localparam int                      FQ_PTR_W     = $clog2(DECOMP_DEPTH);

   typedef struct packed {
      logic [DECOMP_WIDTH-1:0] pc;
      logic [DECOMP_WIDTH-1:0] instr;
   } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/decomp_fetch_queue_storage.sv
`default_nettype none
// ============================================================================
// Module   : fq_storage
// Purpose  : DEPTH-entry register array, two write ports (wp, wp+1) and one
//            asynchronous read port.
// Revision : 1.0
// ============================================================================
module fq_storage
   import decomp_pkg::*;
#(
   parameter int DEPTH = DECOMP_DEPTH,
   parameter int PTR_W = FQ_PTR_W
) (
   input  logic             clk,
   input  logic             we0_i,
   input  logic             we1_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  fq_entry_t        wdata0_i,
   input  fq_entry_t        wdata1_i,
   input  logic [PTR_W-1:0] raddr_i,
   output fq_entry_t        rdata_o
);

   fq_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] waddr1;

   // Second port wraps naturally, so a two-word write can straddle slot 0.
   assign waddr1 = waddr_i + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (we0_i) mem_q[waddr_i] <= wdata0_i;
      if (we1_i) mem_q[waddr1]  <= wdata1_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/decomp_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : decomp_fetch_queue
// Purpose  : Instruction/PC FIFO between decompressor and CPU, with one- or
//            two-word pushes and flush on redirect.
// Options  : DECOMP_QUEUE_STATS_EN enables the saturating flush counter.
// Revision : 1.0
// ============================================================================
module decomp_fetch_queue
   import decomp_pkg::*;
#(
   parameter int               WIDTH = DECOMP_WIDTH,
   parameter int               DEPTH = DECOMP_DEPTH,
   parameter logic [WIDTH-1:0] PCADD = DECOMP_PCADD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_two,
   input  logic [WIDTH-1:0]         in_instr0,
   input  logic [WIDTH-1:0]         in_instr1,
   input  logic [WIDTH-1:0]         in_pc,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_instr,
   output logic [WIDTH-1:0]         out_pc,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              stat_flushes
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] push_words;
   logic             push, pop;
   fq_entry_t        wr_entry0, wr_entry1, rd_entry;

   // Room for two words is always required, so in_ready never sees out_ready.
   assign in_ready  = (count_q <= CNT_W'(DEPTH - 2));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      push_words = '0;
      if (push) push_words = in_two ? CNT_W'(2) : CNT_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_words);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + push_words - CNT_W'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_entry0.pc    = in_pc;
   assign wr_entry0.instr = in_instr0;
   assign wr_entry1.pc    = in_pc + PCADD;
   assign wr_entry1.instr = in_instr1;

   fq_storage #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk      (clk),
      .we0_i    (push),
      .we1_i    (push & in_two),
      .waddr_i  (wr_ptr_q),
      .wdata0_i (wr_entry0),
      .wdata1_i (wr_entry1),
      .raddr_i  (rd_ptr_q),
      .rdata_o  (rd_entry)
   );

   assign out_instr = out_valid ? rd_entry.instr : '0;
   assign out_pc    = out_valid ? rd_entry.pc    : '0;
   assign count     = count_q;

`ifdef DECOMP_QUEUE_STATS_EN
   logic [15:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (flush && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stat_q <= '0;
      else        stat_q <= stat_d;
   end

   assign stat_flushes = stat_q;
`else
   assign stat_flushes = 16'h0;
`endif

endmodule
`default_nettype wire
